gc_poll_scheduler: RTL and testbench
====================================

GC_POLL_SCHEDULER -- requirements
Module: gc_poll_scheduler

Interface
REQ-001 Parameter POLL_DIV, default 16'd50000: clocks spent in IDLE between polls.
REQ-002 Parameter TIMEOUT, default 16'd4000: max clocks in REQ waiting for gc_done.
REQ-003 Parameter MISS_LIMIT, default 2'd3: consecutive failed polls before link is declared lost.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 gc_req  output  1  poll request to GC serial engine; level, held until done/timeout.
REQ-007 gc_done  input  1  one-cycle pulse: GC response frame complete; gc_data valid this cycle.
REQ-008 gc_data  input  64  response frame: [63:48] buttons/status, [47:40] stick X, [39:32] stick Y, [31:24] C X, [23:16] C Y, [15:0] triggers.
REQ-009 n64_busy  input  1  N64 responder is serialising the current snapshot; outputs must not change.
REQ-010 Buttons  output  16  committed gc_data[63:48].
REQ-011 JoyL  output  16  committed {stick X, stick Y}; feeds the analog mapper.
REQ-012 JoyR  output  16  committed {C X, C Y}.
REQ-013 analog_check  output  1  1 = link lost or never valid (mapper forces neutral); 0 = JoyL valid.
REQ-014 miss_cnt  output  2  consecutive-miss counter, saturating.

Function
REQ-015 FSM states SHALL be IDLE, REQ, CHECK; reset state IDLE.
REQ-016 IDLE: period counter SHALL clear on entry, increment each clock, and move to REQ when it reaches POLL_DIV-1.
REQ-017 REQ: gc_req SHALL be 1 in every REQ cycle and 0 in all other states; timeout counter clears on entry.
REQ-018 REQ with gc_done=1: load gc_data into a 48-bit staging register ({[63:48],[47:16]}), go CHECK next clock.
REQ-019 REQ without gc_done for TIMEOUT clocks: record a miss, return to IDLE; gc_done on the expiry cycle SHALL win over timeout.
REQ-020 gc_done outside REQ SHALL be ignored (no staging load, no counter change).
REQ-021 CHECK (1 clock): frame valid iff staged[63:61]==3'b000 and staged[55]==1; then go IDLE.
REQ-022 Valid frame: miss_cnt<=0, analog_check<=0, set pending flag.
REQ-023 Invalid frame: recorded as a miss; pending flag unchanged.
REQ-024 Miss: miss_cnt increments, saturating at MISS_LIMIT; when the increment reaches MISS_LIMIT, analog_check<=1.
REQ-025 Commit: when pending=1 and n64_busy=0, Buttons/JoyL/JoyR SHALL load from staging in the same clock and pending clears.
REQ-026 While n64_busy=1, Buttons/JoyL/JoyR SHALL hold; a later valid frame overwrites staging (newest wins); commit occurs on the first clock with n64_busy=0.
REQ-027 analog_check is not gated by n64_busy.
REQ-028 A valid frame in CHECK and a commit in the same clock: commit uses the newly staged data (pending set and consumed in one clock).
REQ-029 Counters SHALL be 16-bit and not wrap; comparisons are unsigned.

Reset
REQ-030 On rst=1, immediately: state IDLE, gc_req=0, Buttons=16'h0000, JoyL=16'h8080, JoyR=16'h8080, analog_check=1, miss_cnt=0, pending=0, staging cleared, all counters 0.
REQ-031 rst asserted mid-REQ SHALL drop gc_req asynchronously; a gc_done arriving during reset is discarded.
REQ-032 After rst deasserts, first gc_req SHALL rise exactly POLL_DIV clocks later.

Verification
REQ-033 POLL_DIV=10: release reset -> gc_req rises at clock 10; gc_done with gc_data=64'h0080_7F81_C040_0000 -> next-clock CHECK, following clock JoyL=16'h7F81, JoyR=16'hC040, Buttons=16'h0080, analog_check=0.
REQ-034 TIMEOUT=20, no gc_done for three polls -> gc_req high 20 clocks each; miss_cnt 1,2,3; analog_check=1 after the 3rd; JoyL holds its last value.
REQ-035 n64_busy=1, two valid frames (JoyL 16'h1020, then 16'h3040) -> outputs unchanged while busy; on the first clock n64_busy=0, JoyL=16'h3040.
REQ-036 Invalid frame gc_data[63:48]=16'hE000 -> miss_cnt+1, outputs unchanged; next valid frame -> miss_cnt=0.
REQ-037 gc_done in IDLE ignored; gc_done on the TIMEOUT expiry cycle accepted as valid data, no miss counted.
REQ-038 rst pulsed while gc_req=1 -> gc_req=0 in the same cycle, JoyL=16'h8080, analog_check=1, POLL_DIV restart.

Source files
------------

// File: rtl/gc_poll_scheduler_if.sv
// Signal bundle between the GameCube poll scheduler and its neighbours: the GC serial
// engine (request/response) and the N64 responder (busy/committed snapshot).
interface gc_poll_scheduler_if;
  logic        gc_req;
  logic        gc_done;
  logic [63:0] gc_data;
  logic        n64_busy;
  logic [15:0] Buttons;
  logic [15:0] JoyL;
  logic [15:0] JoyR;
  logic        analog_check;
  logic [1:0]  miss_cnt;

  modport master (
    output gc_req, Buttons, JoyL, JoyR, analog_check, miss_cnt,
    input  gc_done, gc_data, n64_busy
  );

  modport slave (
    input  gc_req, Buttons, JoyL, JoyR, analog_check, miss_cnt,
    output gc_done, gc_data, n64_busy
  );
endinterface

// File: rtl/gc_poll_scheduler.sv
// Periodically polls the GC controller, validates each response frame and commits it
// to the N64-facing snapshot only while the N64 responder is not serialising.
module gc_poll_scheduler #(
  parameter logic [15:0] POLL_DIV   = 16'd50000,
  parameter logic [15:0] TIMEOUT    = 16'd4000,
  parameter logic [1:0]  MISS_LIMIT = 2'd3
) (
  input logic clk,
  input logic rst,
  gc_poll_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, CHECK} state_t;

  state_t      state;
  logic [15:0] pollCnt;
  logic [15:0] toutCnt;
  logic [47:0] staging;
  logic        pending;

  logic        frameValid;
  logic        validHit;
  logic        missHit;
  logic        commitNow;
  logic [1:0]  missInc;
  logic        unusedTriggers;

  function automatic logic [1:0] satInc(input logic [1:0] v);
    return (v >= MISS_LIMIT) ? v : v + 2'd1;
  endfunction

  // Trigger bytes are carried by the frame but never forwarded.
  assign unusedTriggers = ^bus.gc_data[15:0];

  // staging[47:45] / staging[39] are frame bits [63:61] / [55]
  assign frameValid = (staging[47:45] == 3'b000) && staging[39];

  always_comb begin
    validHit  = (state == CHECK) && frameValid;
    missHit   = ((state == CHECK) && !frameValid) ||
                ((state == REQ) && !bus.gc_done && (toutCnt == TIMEOUT - 16'd1));
    missInc   = satInc(bus.miss_cnt);
    commitNow = (pending || validHit) && !bus.n64_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      pollCnt          <= '0;
      toutCnt          <= '0;
      staging          <= '0;
      pending          <= 1'b0;
      bus.gc_req       <= 1'b0;
      bus.Buttons      <= 16'h0000;
      bus.JoyL         <= 16'h8080;
      bus.JoyR         <= 16'h8080;
      bus.analog_check <= 1'b1;
      bus.miss_cnt     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pollCnt == POLL_DIV - 16'd1) begin
            state      <= REQ;
            bus.gc_req <= 1'b1;
            toutCnt    <= '0;
          end else begin
            pollCnt <= pollCnt + 16'd1;
          end
        end
        REQ: begin
          // A response on the expiry cycle takes priority over the timeout.
          if (bus.gc_done) begin
            staging    <= {bus.gc_data[63:48], bus.gc_data[47:16]};
            state      <= CHECK;
            bus.gc_req <= 1'b0;
          end else if (toutCnt == TIMEOUT - 16'd1) begin
            state      <= IDLE;
            bus.gc_req <= 1'b0;
            pollCnt    <= '0;
          end else begin
            toutCnt <= toutCnt + 16'd1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          pollCnt <= '0;
        end
        default: begin
          state      <= IDLE;
          bus.gc_req <= 1'b0;
          pollCnt    <= '0;
        end
      endcase

      if (validHit) begin
        bus.miss_cnt     <= 2'd0;
        bus.analog_check <= 1'b0;
      end else if (missHit) begin
        bus.miss_cnt <= missInc;
        if (missInc == MISS_LIMIT) bus.analog_check <= 1'b1;
      end

      // Newest staged frame wins; a frame validated this clock can commit immediately.
      if (commitNow) begin
        bus.Buttons <= staging[47:32];
        bus.JoyL    <= staging[31:16];
        bus.JoyR    <= staging[15:0];
        pending     <= 1'b0;
      end else if (validHit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// Randomized bench for gc_poll_scheduler against a poll-window/event reference model.
module tb_gc_poll_scheduler;
  localparam logic [15:0] PD = 16'd10;
  localparam logic [15:0] TO = 16'd20;
  localparam logic [1:0]  ML = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gc_poll_scheduler_if bus();

  gc_poll_scheduler #(.POLL_DIV(PD), .TIMEOUT(TO), .MISS_LIMIT(ML)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: absolute-cycle poll windows and transaction outcomes.
  int          n;
  int          reqStart;
  int          checkAt;
  logic [15:0] stB, stL, stR;
  logic [15:0] expB, expL, expR;
  bit          pendM;
  bit          acM;
  int          missM;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, n, act, exp);
    end
  endtask

  task automatic modelReset();
    n        = 0;
    reqStart = int'(PD);
    checkAt  = -1;
    stB = '0; stL = '0; stR = '0;
    expB = 16'h0000; expL = 16'h8080; expR = 16'h8080;
    pendM = 1'b0;
    acM   = 1'b1;
    missM = 0;
  endtask

  function automatic bit reqActive(input int c);
    return (checkAt < 0) && (c >= reqStart) && (c < reqStart + int'(TO));
  endfunction

  // Advance the model across the clock edge that ends cycle c.
  task automatic step(input int c, input bit done, input logic [63:0] d, input bit busy);
    bit validNow = 1'b0;
    bit miss     = 1'b0;
    if (checkAt == c) begin
      checkAt  = -1;
      reqStart = c + 1 + int'(PD);
      if (stB[15:13] == 3'b000 && stB[7]) validNow = 1'b1;
      else miss = 1'b1;
    end else if (reqActive(c)) begin
      if (done) begin
        stB = d[63:48]; stL = d[47:32]; stR = d[31:16];
        checkAt = c + 1;
      end else if (c == reqStart + int'(TO) - 1) begin
        miss     = 1'b1;
        reqStart = c + 1 + int'(PD);
      end
    end
    if (validNow) begin
      missM = 0; acM = 1'b0; pendM = 1'b1;
    end
    if (miss) begin
      if (missM < int'(ML)) missM++;
      if (missM == int'(ML)) acM = 1'b1;
    end
    if (pendM && !busy) begin
      expB = stB; expL = stL; expR = stR; pendM = 1'b0;
    end
  endtask

  task automatic checkOutputs();
    check("gc_req", 64'(bus.gc_req), 64'(reqActive(n)));
    check("Buttons", 64'(bus.Buttons), 64'(expB));
    check("JoyL", 64'(bus.JoyL), 64'(expL));
    check("JoyR", 64'(bus.JoyR), 64'(expR));
    check("analog_check", 64'(bus.analog_check), 64'(acM));
    check("miss_cnt", 64'(bus.miss_cnt), 64'(missM));
  endtask

  task automatic resetChecks(input string tag);
    check({tag, "_gc_req"}, 64'(bus.gc_req), 64'd0);
    check({tag, "_Buttons"}, 64'(bus.Buttons), 64'h0000);
    check({tag, "_JoyL"}, 64'(bus.JoyL), 64'h8080);
    check({tag, "_JoyR"}, 64'(bus.JoyR), 64'h8080);
    check({tag, "_analog"}, 64'(bus.analog_check), 64'd1);
    check({tag, "_miss"}, 64'(bus.miss_cnt), 64'd0);
  endtask

  // mode 0: never respond, 1: frequent responses (also outside REQ),
  // 2: respond only on the timeout expiry cycle, 3: rare responses
  task automatic runCycle(input int mode);
    logic [63:0] d;
    bit          dn;
    @(posedge clk);
    n++;
    #1;
    d = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) begin
      d[63:61] = 3'b000;
      d[55]    = 1'b1;
    end
    case (mode)
      0:       dn = 1'b0;
      1:       dn = ($urandom_range(0, 3) == 0);
      2:       dn = reqActive(n) && (n == reqStart + int'(TO) - 1);
      default: dn = ($urandom_range(0, 39) == 0);
    endcase
    if ($urandom_range(0, 19) == 0) bus.n64_busy = ~bus.n64_busy;
    bus.gc_done = dn;
    bus.gc_data = d;
    @(negedge clk);
    checkOutputs();
    step(n, dn, d, bus.n64_busy);
  endtask

  initial begin
    bit found;
    bus.gc_done  = 1'b0;
    bus.gc_data  = '0;
    bus.n64_busy = 1'b0;
    modelReset();

    // Power-on reset with a stray response that must be discarded.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.gc_done = 1'b1;
    bus.gc_data = 64'h0080_7F81_C040_0000;
    @(posedge clk);
    #1 bus.gc_done = 1'b0;
    @(negedge clk);
    resetChecks("por");
    @(posedge clk);
    #2 rst = 1'b0;
    modelReset();

    for (int seg = 0; seg < 8; seg++)
      for (int k = 0; k < 200; k++) runCycle(seg % 4);

    // Reset asserted in the middle of a request window.
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      runCycle(0);
      if (reqActive(n) && reqActive(n + 1)) found = 1'b1;
    end
    check("rstWindowFound", 64'(found), 64'd1);
    @(posedge clk);
    n++;
    #1 check("preRstReq", 64'(bus.gc_req), 64'd1);
    #1 rst = 1'b1;
    #1 resetChecks("midReq");
    @(negedge clk);
    bus.gc_done = 1'b1;
    bus.gc_data = 64'h0080_1234_5678_0000;
    @(posedge clk);
    #1 bus.gc_done = 1'b0;
    @(negedge clk);
    resetChecks("rstHeld");
    @(posedge clk);
    #2 rst = 1'b0;
    modelReset();

    for (int seg = 0; seg < 4; seg++)
      for (int k = 0; k < 150; k++) runCycle((seg + 1) % 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
